// File: rtl/spi_acc_pkg.sv
// Shared types and constants for the accelerometer SPI register reader.
package spi_acc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        XFER,
        CS_HOLD,
        DONE
    } state_t;

    localparam logic [7:0] CMD_READ  = 8'h0B;
    localparam logic [7:0] CMD_WRITE = 8'h0A;

    localparam logic [7:0] DEVID_AD = 8'h00;
    localparam logic [7:0] XDATA    = 8'h08;
    localparam logic [7:0] YDATA    = 8'h09;
    localparam logic [7:0] ZDATA    = 8'h0A;

    // Three bytes, two SCLK edges per bit.
    localparam int XFER_TICKS = 48;

endpackage

// File: rtl/spi_reg_reader_if.sv
// Request/response handshake plus the four SPI pins of the register reader.
interface spi_reg_reader_if;
    logic       start;
    logic [7:0] reg_addr;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;

    modport master (
        input  start, reg_addr, miso,
        output busy, done, rx_data, sclk, cs_n, mosi
    );

    modport slave (
        output start, reg_addr, miso,
        input  busy, done, rx_data, sclk, cs_n, mosi
    );
endinterface

// File: rtl/spi_half_tick.sv
// Half-period tick generator: one tick every CLK_DIV cycles while enabled.
module spi_half_tick #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV);

    generate
        if (CLK_DIV < 2) begin : g_bad_div
            $error("spi_half_tick: CLK_DIV must be at least 2");
        end
    endgenerate

    logic [CW-1:0] cnt;
    logic          term;

    assign term = (cnt == CW'(CLK_DIV - 1));
    assign tick = enable && term;

    // Held at zero while disabled so every enable starts a full half-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!enable || term)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/spi_reg_reader.sv
// Mode-0 SPI master issuing one {CMD_READ, addr, dummy} transfer per request
// and returning the third received byte on rx_data.
module spi_reg_reader #(
    parameter int         CLK_DIV  = 50,
    parameter logic [7:0] CMD_READ = 8'h0B
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_reg_reader_if.master bus
);
    import spi_acc_pkg::*;

    state_t      state, state_nxt;
    logic [23:0] tx_sh, tx_nxt;
    logic [7:0]  rx_sh, rx_nxt;
    logic [5:0]  xfer_cnt, cnt_nxt;
    logic        cs_n_q, cs_n_nxt;
    logic        sclk_q, sclk_nxt;
    logic        mosi_q, mosi_nxt;
    logic        busy_q, busy_nxt;
    logic        done_q, done_nxt;
    logic [7:0]  rx_data_q, rx_data_nxt;
    logic        tick;

    spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state != IDLE),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx_sh     <= '0;
            rx_sh     <= '0;
            xfer_cnt  <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
        end else begin
            state     <= state_nxt;
            tx_sh     <= tx_nxt;
            rx_sh     <= rx_nxt;
            xfer_cnt  <= cnt_nxt;
            cs_n_q    <= cs_n_nxt;
            sclk_q    <= sclk_nxt;
            mosi_q    <= mosi_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            rx_data_q <= rx_data_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tx_nxt      = tx_sh;
        rx_nxt      = rx_sh;
        cnt_nxt     = xfer_cnt;
        cs_n_nxt    = cs_n_q;
        sclk_nxt    = sclk_q;
        mosi_nxt    = mosi_q;
        busy_nxt    = busy_q;
        done_nxt    = 1'b0;
        rx_data_nxt = rx_data_q;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    tx_nxt    = {CMD_READ, bus.reg_addr, 8'h00};
                    mosi_nxt  = CMD_READ[7];
                    cs_n_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = CS_SETUP;
                end
            end
            CS_SETUP: begin
                if (tick)
                    state_nxt = XFER;
            end
            XFER: begin
                // xfer_cnt holds ticks already taken, so an even count means an odd (rising) tick.
                if (tick) begin
                    cnt_nxt = xfer_cnt + 6'd1;
                    if (!xfer_cnt[0]) begin
                        sclk_nxt = 1'b1;
                        rx_nxt   = {rx_sh[6:0], bus.miso};
                    end else begin
                        sclk_nxt = 1'b0;
                        tx_nxt   = {tx_sh[22:0], 1'b0};
                        mosi_nxt = tx_sh[22];
                        if (xfer_cnt == 6'(XFER_TICKS - 1)) begin
                            mosi_nxt  = 1'b0;
                            state_nxt = CS_HOLD;
                        end
                    end
                end
            end
            CS_HOLD: begin
                if (tick) begin
                    cs_n_nxt    = 1'b1;
                    done_nxt    = 1'b1;
                    rx_data_nxt = rx_sh;
                    state_nxt   = DONE;
                end
            end
            DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.cs_n    = cs_n_q;
    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;
endmodule
